// File: rtl/cpu_if_block_if.sv
// CPU bus bundle for cpu_if_block: chip select, control/data select, strobes, data and interrupt.
// Latency: n/a (wires only).
// Backpressure: none; the CPU bus is strobe-driven and never stalls.
// Ports: master = CPU side (drives select/strobes/write data), slave = block side (drives read data, n_int).
interface cpu_if_block_if;
    logic       n_cs;      // active-low chip select
    logic       c_nd;      // 1 = control/status, 0 = data
    logic       n_wr;      // active-low write strobe
    logic       n_rd;      // active-low read strobe
    logic [7:0] data_in;   // CPU write data
    logic [7:0] data_out;  // CPU read data (registered)
    logic       n_int;     // active-low interrupt

    modport master (
        output n_cs, c_nd, n_wr, n_rd, data_in,
        input  data_out, n_int
    );

    modport slave (
        input  n_cs, c_nd, n_wr, n_rd, data_in,
        output data_out, n_int
    );
endinterface

// File: rtl/cpu_if_block.sv
// CPU register interface for a UART: mode/command programming, tx/rx data, sticky status.
// Latency: one clock from strobe edge to register update / read data / strobe pulse.
// Backpressure: none; accesses are edge events and the serial side is told via one-cycle pulses.
// Ports: clk/rst_n; cpu (CPU bus, slave modport); tx_data_out/rx_data_in byte paths;
//        line config (parity, extra_stop_bit, eight_data_bits, clk_div_baud_out, break_en);
//        rdy gating (tx/rx_rdy_en, tx_rdy, rx_rdy); n_rd_out/n_wr_out pulses; error/ready inputs;
//        n_external_reset to the serial engines.
module cpu_if_block (
    input  logic         clk,
    input  logic         rst_n,
    cpu_if_block_if.slave cpu,
    output logic [7:0]   tx_data_out,
    input  logic [7:0]   rx_data_in,
    output logic         tx_rdy,
    output logic         rx_rdy,
    output logic [1:0]   parity,
    output logic         extra_stop_bit,
    output logic         eight_data_bits,
    output logic         break_en,
    output logic         rx_rdy_en,
    output logic         tx_rdy_en,
    output logic [31:0]  clk_div_baud_out,
    output logic         n_rd_out,
    output logic         n_wr_out,
    input  logic         frame_error_in,
    input  logic         parity_error_in,
    input  logic         overrun_error_in,
    input  logic         tx_rdy_in,
    input  logic         rx_rdy_in,
    output logic         n_external_reset
);

    typedef enum logic {
        EXPECT_MODE = 1'b0,
        EXPECT_CMD  = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] baud_sel;
    logic       wr_q;       // previous n_wr sample
    logic       rd_q;       // previous n_rd sample
    logic       fe, pe, oe; // sticky error flags
    logic       int_rst;    // one-cycle soft-reset pulse from command bit 6

    logic       wr_evt, rd_evt, ctl_wr, dat_wr, clear_err;
    logic [7:0] status;

    // Event = first sampled-low cycle of a strobe; a write masks a simultaneous read.
    assign wr_evt    = ~cpu.n_cs & ~cpu.n_wr & wr_q;
    assign rd_evt    = ~cpu.n_cs & ~cpu.n_rd & rd_q & ~wr_evt;
    assign ctl_wr    = wr_evt &  cpu.c_nd;
    assign dat_wr    = wr_evt & ~cpu.c_nd;
    assign clear_err = ctl_wr & (state == EXPECT_CMD) & cpu.data_in[4];

    assign tx_rdy = tx_rdy_in & tx_rdy_en;
    assign rx_rdy = rx_rdy_in & rx_rdy_en;
    assign status = {2'b00, fe, oe, pe, tx_rdy_in, rx_rdy, tx_rdy};

    assign cpu.n_int        = ~(rx_rdy | fe | pe | oe);
    assign n_external_reset = rst_n & ~int_rst;

    always_comb begin
        clk_div_baud_out = 32'd5208;
        case (baud_sel)
            2'b00: clk_div_baud_out = 32'd5208;
            2'b01: clk_div_baud_out = 32'd1302;
            2'b10: clk_div_baud_out = 32'd434;
            2'b11: clk_div_baud_out = 32'd868;
            default: clk_div_baud_out = 32'd5208;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= EXPECT_MODE;
            baud_sel        <= 2'b00;
            eight_data_bits <= 1'b0;
            parity          <= 2'b00;
            extra_stop_bit  <= 1'b0;
            tx_rdy_en       <= 1'b0;
            rx_rdy_en       <= 1'b0;
            break_en        <= 1'b0;
            // Strobe history starts high so a strobe already low at release counts.
            wr_q            <= 1'b1;
            rd_q            <= 1'b1;
            fe              <= 1'b0;
            pe              <= 1'b0;
            oe              <= 1'b0;
            int_rst         <= 1'b0;
            n_rd_out        <= 1'b1;
            n_wr_out        <= 1'b1;
            tx_data_out     <= 8'h00;
            cpu.data_out    <= 8'h00;
        end else begin
            wr_q     <= cpu.n_wr;
            rd_q     <= cpu.n_rd;
            n_wr_out <= ~dat_wr;
            n_rd_out <= ~(rd_evt & ~cpu.c_nd);
            int_rst  <= 1'b0;

            if (ctl_wr) begin
                case (state)
                    EXPECT_MODE: begin
                        baud_sel        <= cpu.data_in[1:0];
                        eight_data_bits <= (cpu.data_in[3:2] == 2'b11);
                        parity          <= cpu.data_in[4] ? (cpu.data_in[5] ? 2'b10 : 2'b01) : 2'b00;
                        extra_stop_bit  <= cpu.data_in[7];
                        state           <= EXPECT_CMD;
                    end
                    EXPECT_CMD: begin
                        if (cpu.data_in[6]) begin
                            // Soft reset: back to mode programming with defaults.
                            state           <= EXPECT_MODE;
                            baud_sel        <= 2'b00;
                            eight_data_bits <= 1'b0;
                            parity          <= 2'b00;
                            extra_stop_bit  <= 1'b0;
                            tx_rdy_en       <= 1'b0;
                            rx_rdy_en       <= 1'b0;
                            break_en        <= 1'b0;
                            int_rst         <= 1'b1;
                        end else begin
                            tx_rdy_en <= cpu.data_in[0];
                            rx_rdy_en <= cpu.data_in[2];
                            break_en  <= cpu.data_in[3];
                        end
                    end
                    default: state <= EXPECT_MODE;
                endcase
            end

            if (dat_wr) begin
                tx_data_out <= cpu.data_in;
            end

            if (rd_evt) begin
                cpu.data_out <= cpu.c_nd ? status : rx_data_in;
            end

            // Set has priority over a same-cycle clear.
            fe <= frame_error_in   | (fe & ~clear_err);
            pe <= parity_error_in  | (pe & ~clear_err);
            oe <= overrun_error_in | (oe & ~clear_err);
        end
    end

endmodule

// File: tb/tb_cpu_if_block.sv
module tb_cpu_if_block;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tx_data_out;
    logic [7:0]  rx_data_in;
    logic        tx_rdy, rx_rdy;
    logic [1:0]  parity;
    logic        extra_stop_bit, eight_data_bits, break_en, rx_rdy_en, tx_rdy_en;
    logic [31:0] clk_div_baud_out;
    logic        n_rd_out, n_wr_out;
    logic        frame_error_in, parity_error_in, overrun_error_in, tx_rdy_in, rx_rdy_in;
    logic        n_external_reset;

    cpu_if_block_if bus ();

    always #10 clk = ~clk;

    cpu_if_block dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpu              (bus),
        .tx_data_out      (tx_data_out),
        .rx_data_in       (rx_data_in),
        .tx_rdy           (tx_rdy),
        .rx_rdy           (rx_rdy),
        .parity           (parity),
        .extra_stop_bit   (extra_stop_bit),
        .eight_data_bits  (eight_data_bits),
        .break_en         (break_en),
        .rx_rdy_en        (rx_rdy_en),
        .tx_rdy_en        (tx_rdy_en),
        .clk_div_baud_out (clk_div_baud_out),
        .n_rd_out         (n_rd_out),
        .n_wr_out         (n_wr_out),
        .frame_error_in   (frame_error_in),
        .parity_error_in  (parity_error_in),
        .overrun_error_in (overrun_error_in),
        .tx_rdy_in        (tx_rdy_in),
        .rx_rdy_in        (rx_rdy_in),
        .n_external_reset (n_external_reset)
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard: expected data-read bytes, expected tx bytes, expected soft-reset pulses.
    logic [7:0] rd_exp_q[$];
    logic [7:0] wr_exp_q[$];
    int         ext_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every low strobe pulse from the DUT is matched against the queues.
    logic       prev_rd_low = 1'b0;
    logic       prev_wr_low = 1'b0;
    logic       prev_ext_low = 1'b0;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!n_rd_out) begin
                if (rd_exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rd_unexpected: n_rd_out low with data 0x%0h, no read expected", bus.data_out);
                end else begin
                    mon_exp = rd_exp_q.pop_front();
                    check("rd_data", {24'd0, bus.data_out}, {24'd0, mon_exp});
                end
                check("rd_pulse_width", {31'd0, prev_rd_low}, 32'd0);
            end
            if (!n_wr_out) begin
                if (wr_exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL wr_unexpected: n_wr_out low with tx 0x%0h, no write expected", tx_data_out);
                end else begin
                    mon_exp = wr_exp_q.pop_front();
                    check("wr_data", {24'd0, tx_data_out}, {24'd0, mon_exp});
                end
                check("wr_pulse_width", {31'd0, prev_wr_low}, 32'd0);
            end
            if (!n_external_reset) begin
                if (ext_exp == 0) begin
                    tests++; fails++;
                    $display("FAIL ext_rst_unexpected: n_external_reset low, none expected");
                end else begin
                    ext_exp--;
                end
                check("ext_rst_width", {31'd0, prev_ext_low}, 32'd0);
            end
            prev_rd_low  = !n_rd_out;
            prev_wr_low  = !n_wr_out;
            prev_ext_low = !n_external_reset;
        end
    end

    task automatic cpu_wr(input logic cnd, input logic [7:0] d);
        @(posedge clk); #1;
        bus.c_nd = cnd; bus.data_in = d; bus.n_wr = 1'b0;
        @(posedge clk); #1;
        bus.n_wr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic cpu_rd(input logic cnd);
        @(posedge clk); #1;
        bus.c_nd = cnd; bus.n_rd = 1'b0;
        @(posedge clk); #1;
        bus.n_rd = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_err(input int which);
        @(posedge clk); #1;
        case (which)
            0: frame_error_in   = 1'b1;
            1: parity_error_in  = 1'b1;
            default: overrun_error_in = 1'b1;
        endcase
        @(posedge clk); #1;
        frame_error_in = 1'b0; parity_error_in = 1'b0; overrun_error_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.n_cs = 1'b0; bus.c_nd = 1'b1; bus.n_wr = 1'b0; bus.n_rd = 1'b1; bus.data_in = 8'h3F;
        rx_data_in = 8'h00;
        frame_error_in = 1'b0; parity_error_in = 1'b0; overrun_error_in = 1'b0;
        tx_rdy_in = 1'b0; rx_rdy_in = 1'b0;
        rst_n = 1'b0;

        // Reset values, with a control write already held on the bus.
        repeat (3) @(negedge clk);
        check("rst_clk_div", clk_div_baud_out, 32'd5208);
        check("rst_data_out", {24'd0, bus.data_out}, 32'h00);
        check("rst_tx_data", {24'd0, tx_data_out}, 32'h00);
        check("rst_strobes", {30'd0, n_rd_out, n_wr_out}, 32'd3);
        check("rst_ext_rst", {31'd0, n_external_reset}, 32'd0);
        check("rst_cfg", {25'd0, parity, extra_stop_bit, eight_data_bits, break_en, rx_rdy_en, tx_rdy_en}, 32'd0);
        check("rst_n_int", {31'd0, bus.n_int}, 32'd1);
        rst_n = 1'b1;

        // Strobe low through release: first clock takes 8'h3F as the mode byte.
        @(posedge clk); #1;
        bus.n_wr = 1'b1;
        @(posedge clk); #1;
        check("mode3f_eight", {31'd0, eight_data_bits}, 32'd1);
        check("mode3f_parity", {30'd0, parity}, 32'd2);
        check("mode3f_stop", {31'd0, extra_stop_bit}, 32'd0);
        check("mode3f_clk_div", clk_div_baud_out, 32'd868);
        check("ext_rst_released", {31'd0, n_external_reset}, 32'd1);

        // Data read of rx byte 15.
        rx_data_in = 8'd15;
        rd_exp_q.push_back(8'h0F);
        cpu_rd(1'b0);
        check("data_rd_hold", {24'd0, bus.data_out}, 32'h0F);

        // Data write.
        wr_exp_q.push_back(8'h3F);
        cpu_wr(1'b0, 8'h3F);
        check("tx_data", {24'd0, tx_data_out}, 32'h3F);

        // Command 0x05 (state must be EXPECT_CMD: baud stays 868).
        tx_rdy_in = 1'b1; rx_rdy_in = 1'b1;
        cpu_wr(1'b1, 8'h05);
        check("cmd05_en", {30'd0, tx_rdy_en, rx_rdy_en}, 32'd3);
        check("cmd05_rdy", {30'd0, tx_rdy, rx_rdy}, 32'd3);
        check("cmd05_n_int", {31'd0, bus.n_int}, 32'd0);
        check("cmd05_break", {31'd0, break_en}, 32'd0);
        check("cmd05_clk_div", clk_div_baud_out, 32'd868);

        cpu_wr(1'b1, 8'h0D);
        check("cmd0d_break", {31'd0, break_en}, 32'd1);

        // Parity error sticky, status read, then clear.
        pulse_err(1);
        cpu_rd(1'b1);
        check("status_pe", {24'd0, bus.data_out}, 32'h0F);
        cpu_wr(1'b1, 8'h10);
        check("cmd10_n_int", {31'd0, bus.n_int}, 32'd1);
        check("cmd10_en", {29'd0, break_en, rx_rdy_en, tx_rdy_en}, 32'd0);
        cpu_rd(1'b1);
        check("status_cleared", {24'd0, bus.data_out}, 32'h04);

        // Overrun sticky.
        pulse_err(2);
        cpu_rd(1'b1);
        check("status_oe", {24'd0, bus.data_out}, 32'h14);
        cpu_wr(1'b1, 8'h10);

        // Frame error asserted exactly in the clearing cycle: set wins.
        @(posedge clk); #1;
        bus.c_nd = 1'b1; bus.data_in = 8'h10; bus.n_wr = 1'b0; frame_error_in = 1'b1;
        @(posedge clk); #1;
        bus.n_wr = 1'b1; frame_error_in = 1'b0;
        @(posedge clk); #1;
        check("set_wins_n_int", {31'd0, bus.n_int}, 32'd0);
        cpu_rd(1'b1);
        check("status_fe", {24'd0, bus.data_out}, 32'h24);
        cpu_wr(1'b1, 8'h10);
        check("fe_cleared_n_int", {31'd0, bus.n_int}, 32'd1);

        // Simultaneous write and read: only the write happens.
        @(posedge clk); #1;
        bus.c_nd = 1'b0; bus.data_in = 8'hA5; rx_data_in = 8'h5A; bus.n_wr = 1'b0; bus.n_rd = 1'b0;
        wr_exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        bus.n_wr = 1'b1; bus.n_rd = 1'b1;
        @(posedge clk); #1;
        check("simul_tx", {24'd0, tx_data_out}, 32'hA5);
        check("simul_rd_ignored", {24'd0, bus.data_out}, 32'h24);

        // Chip select high: nothing happens.
        bus.n_cs = 1'b1;
        cpu_wr(1'b0, 8'h77);
        cpu_rd(1'b0);
        cpu_wr(1'b1, 8'h40);
        bus.n_cs = 1'b0;
        check("cs_high_tx", {24'd0, tx_data_out}, 32'hA5);
        check("cs_high_rd", {24'd0, bus.data_out}, 32'h24);
        check("cs_high_clk_div", clk_div_baud_out, 32'd868);

        // Soft reset via command bit 6.
        cpu_wr(1'b1, 8'h05);
        ext_exp = 1;
        cpu_wr(1'b1, 8'h40);
        check("cmd40_pulse_seen", ext_exp, 0);
        check("cmd40_cfg", {25'd0, parity, extra_stop_bit, eight_data_bits, break_en, rx_rdy_en, tx_rdy_en}, 32'd0);
        check("cmd40_clk_div", clk_div_baud_out, 32'd5208);
        check("cmd40_rdy", {29'd0, tx_rdy, rx_rdy, bus.n_int}, 32'd1);

        // Next control byte is a mode byte.
        cpu_wr(1'b1, 8'h82);
        check("mode82_clk_div", clk_div_baud_out, 32'd434);
        check("mode82_stop", {31'd0, extra_stop_bit}, 32'd1);
        ext_exp = 1;
        cpu_wr(1'b1, 8'h40);
        cpu_wr(1'b1, 8'h00);
        check("mode00_clk_div", clk_div_baud_out, 32'd5208);
        cpu_wr(1'b1, 8'h05);
        check("after_mode00_cmd", {30'd0, tx_rdy_en, rx_rdy_en}, 32'd3);
        check("after_mode00_clk_div", clk_div_baud_out, 32'd5208);

        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_empty", rd_exp_q.size(), 0);
        check("wr_queue_empty", wr_exp_q.size(), 0);
        check("ext_pulses_all_seen", ext_exp, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_if_block.md
CPU_IF_BLOCK -- requirements
Module: CpuIfBlock

Interface
REQ-001 CLK50M  in  1  50 MHz system clock; all state changes on its rising edge.
REQ-002 n_RST  in  1  Reset: one clock; reset is asynchronous and active-low.
REQ-003 n_CS  in  1  Active-low chip select; gates all CPU accesses.
REQ-004 C_nD  in  1  1 = control/status access, 0 = data access.
REQ-005 n_WR, n_RD  in  1 each  Active-low CPU write and read strobes.
REQ-006 DATA_in  in  8  CPU write data.
REQ-007 DATA_out  out  8  CPU read data.
REQ-008 n_INT  out  1  Active-low interrupt.
REQ-009 Tx_RDY, Rx_RDY  out  1 each  Gated transmitter/receiver ready flags.
REQ-010 tx_data_out  out  8  Latched transmit byte.
REQ-011 rx_data_in  in  8  Received byte from the receiver.
REQ-012 parity  out  2  00 none, 01 odd, 10 even.
REQ-013 extra_stop_bit, eight_data_bits, break_en, rx_rdy_en, tx_rdy_en  out  1 each  Line configuration and enables.
REQ-014 clk_div_baud_out  out  32  CLK50M cycles per bit.
REQ-015 n_rd_out, n_wr_out  out  1 each  Active-low one-cycle pulses: receive byte consumed, transmit byte loaded.
REQ-016 frame_error_in, parity_error_in, overrun_error_in, tx_rdy_in, rx_rdy_in  in  1 each  Status from the receiver and transmitter.
REQ-017 n_external_reset  out  1  Active-low reset to the receiver and transmitter.

Function
REQ-018 Strobe detection: n_WR and n_RD are registered each cycle; a write or read event is the first cycle a strobe is sampled low after being high, with n_CS low. The previous-strobe registers reset to 1, so a strobe held low through reset release is an event on the first clock.
REQ-019 Control-write state machine: states EXPECT_MODE (the reset state) and EXPECT_CMD.
- A control write (C_nD=1) in EXPECT_MODE loads the mode register and moves to EXPECT_CMD.
- A control write in EXPECT_CMD loads the command register.
REQ-020 Mode byte m:
- m[1:0] selects clk_div_baud_out: 00→5208, 01→1302, 10→434, 11→868.
- eight_data_bits = (m[3:2]==2'b11).
- parity = m[4] ? (m[5] ? 2'b10 : 2'b01) : 2'b00.
- extra_stop_bit = m[7].
REQ-021 Command byte c:
- c[0] sets tx_rdy_en.
- c[2] sets rx_rdy_en.
- c[3] sets break_en.
- c[4] = 1 clears all sticky error flags; this bit is not stored.
- c[6] = 1 returns the state machine to EXPECT_MODE, clears mode/command outputs to their reset values, and drives n_external_reset low for exactly one cycle.
- c[1], c[5], c[7] are ignored.
REQ-022 Data write (C_nD=0):
- tx_data_out <= DATA_in.
- n_wr_out is low for the next cycle only.
REQ-023 Data read (C_nD=0): DATA_out <= rx_data_in, and n_rd_out is low for the next cycle only.
REQ-024 Status read (C_nD=1): DATA_out <= {2'b00, FE, OE, PE, tx_rdy_in, Rx_RDY, Tx_RDY}.
REQ-025 DATA_out is registered; it holds its last value while no read is active and is 8'h00 after reset.
REQ-026 Error flags FE, PE and OE are sticky: each is set in any cycle its *_error_in input is high, and cleared by c[4] or reset. If set and clear occur in the same cycle, set wins.
REQ-027 Tx_RDY = tx_rdy_in & tx_rdy_en, and Rx_RDY = rx_rdy_in & rx_rdy_en; both are combinational.
REQ-028 n_INT = ~(Rx_RDY | FE | PE | OE).
REQ-029 n_external_reset = n_RST & ~(internal-reset pulse).
REQ-030 Simultaneous read and write events: the write is performed and the read is ignored.
REQ-031 Any access with n_CS high has no effect.

Reset
REQ-032 While n_RST is low:
- state = EXPECT_MODE.
- mode and command fields = 0, so parity=00, eight_data_bits=0, extra_stop_bit=0, break_en=0, rx_rdy_en=0, tx_rdy_en=0.
- clk_div_baud_out = 5208.
- tx_data_out = 8'h00 and DATA_out = 8'h00.
- Error flags are cleared.
- n_rd_out = n_wr_out = 1.
- n_external_reset = 0.
REQ-033 A reset mid-access aborts the access, and no event is generated until the strobe is seen high again, except as described in REQ-018.

Verification
REQ-034 Hold n_WR=0, C_nD=1, DATA_in=8'h3F, then release n_RST → the following are required:
- eight_data_bits=1, parity=10, extra_stop_bit=0, clk_div_baud_out=868.
- State = EXPECT_CMD.
REQ-035 Then set C_nD=0 and n_RD=0 with rx_data_in=15 → DATA_out=8'h0F, and n_rd_out is low for one cycle.
REQ-036 Then set n_RD=1 and n_WR=0 with C_nD=0 and DATA_in=8'h3F → tx_data_out=8'h3F, and n_wr_out is low for one cycle.
REQ-037 Command write 8'h05 with tx_rdy_in=rx_rdy_in=1 and all error inputs at 0 → tx_rdy_en=1, rx_rdy_en=1, Tx_RDY=1, Rx_RDY=1, n_INT=0.
REQ-038 Pulse parity_error_in, then do a status read → DATA_out[3]=1. Then command write 8'h10 (rx_rdy_en returns to 0) → DATA_out[3] reads 0 and n_INT=1.
REQ-039 Command write 8'h40 → n_external_reset is low for one cycle and the outputs return to reset values. The next control write 8'h00 is taken as a mode byte and sets clk_div_baud_out=5208.
